host_command_buffer: RTL

- Upstream neighbour of the GPU controller; sole source of its buffered `command`/`data` inputs.
- Synchronizes the asynchronous host bus strobe and captures command/data/read-flag triples into a FIFO.
- Dispatches FIFO entries to the controller one at a time, holding each until the GPU is neither busy nor rendering.
- For read commands, latches the controller's `dataOut` and returns it to the host with a valid pulse.

---
 rtl/host_command_buffer_if.sv | 31 +++
 rtl/host_command_buffer.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/host_command_buffer_if.sv
// Host pin bus and controller command bus of the host command buffer.
// The slave modport is the buffer itself; master is the host/controller side.
interface host_command_buffer_if;
    logic        hostStrobe;
    logic        hostRead;
    logic [15:0] hostCommand;
    logic [15:0] hostData;
    logic        hostReady;
    logic        hostOverflow;
    logic [15:0] hostDataOut;
    logic        hostReadValid;
    logic [15:0] command;
    logic [15:0] data;
    logic [15:0] dataOut;
    logic        gpuBusy;
    logic        currentlyRendering;

    modport slave (
        input  hostStrobe, hostRead, hostCommand, hostData,
        input  dataOut, gpuBusy, currentlyRendering,
        output hostReady, hostOverflow, hostDataOut, hostReadValid,
        output command, data
    );

    modport master (
        output hostStrobe, hostRead, hostCommand, hostData,
        output dataOut, gpuBusy, currentlyRendering,
        input  hostReady, hostOverflow, hostDataOut, hostReadValid,
        input  command, data
    );
endinterface

// File: rtl/host_command_buffer.sv
// Captures asynchronous host strobes into a FIFO and dispatches entries to the
// GPU controller one at a time, returning read data to the host.
module host_command_buffer #(
    parameter int          FIFO_DEPTH   = 8,
    parameter int          ISSUE_CYCLES = 2,
    parameter logic [15:0] NOP_CMD      = 16'h0000
) (
    input logic                   gpuClock,
    input logic                   reset,
    host_command_buffer_if.slave  bus
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int IW = (ISSUE_CYCLES > 1) ? $clog2(ISSUE_CYCLES) : 1;
    localparam logic [CW-1:0] FULL       = CW'(FIFO_DEPTH);
    localparam logic [IW-1:0] ISSUE_LOAD = IW'(ISSUE_CYCLES - 1);

    typedef struct packed {
        logic        rd;
        logic [15:0] cmd;
        logic [15:0] dat;
    } entry_t;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, READBACK} state_t;

    logic          sync1_q, sync1_d, sync2_q, sync2_d, edge_q, edge_d;
    logic          capture, push, pop;
    entry_t        mem_q [FIFO_DEPTH];
    entry_t        head;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ready_q, ready_d, overflow_q, overflow_d;

    state_t        state_q, state_d;
    logic [IW-1:0] cnt_q, cnt_d;
    logic [15:0]   cmd_q, cmd_d, data_q, data_d, hdo_q, hdo_d;
    logic          rd_q, rd_d, hrv_q, hrv_d;

    // Synchronizer plus edge flop; the pins are sampled on the capture edge.
    always_comb begin
        sync1_d = bus.hostStrobe;
        sync2_d = sync1_q;
        edge_d  = sync2_q;
        capture = sync2_q & ~edge_q;
    end

    always_comb begin
        head       = mem_q[rd_ptr_q];
        pop        = (state_q == IDLE) && (count_q != '0) &&
                     !bus.gpuBusy && !bus.currentlyRendering;
        // A full FIFO still accepts a capture when the head leaves the same cycle.
        push       = capture && ((count_q != FULL) || pop);
        wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d   = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d    = count_q + CW'(push) - CW'(pop);
        ready_d    = (count_d != FULL);
        overflow_d = overflow_q | (capture & ~push);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cmd_d   = cmd_q;
        data_d  = data_q;
        rd_d    = rd_q;
        hdo_d   = hdo_q;
        hrv_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                cmd_d = NOP_CMD;
                if (pop) begin
                    cmd_d   = head.cmd;
                    data_d  = head.dat;
                    rd_d    = head.rd;
                    cnt_d   = ISSUE_LOAD;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (cnt_q == '0) state_d = WAIT;
                else             cnt_d   = cnt_q - 1'b1;
            end
            WAIT: begin
                if (!bus.gpuBusy) begin
                    cmd_d   = NOP_CMD;
                    state_d = rd_q ? READBACK : IDLE;
                end
            end
            READBACK: begin
                hdo_d   = bus.dataOut;
                hrv_d   = 1'b1;
                cmd_d   = NOP_CMD;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge gpuClock) begin
        if (push) mem_q[wr_ptr_q] <= {bus.hostRead, bus.hostCommand, bus.hostData};
    end

    always_ff @(posedge gpuClock or posedge reset) begin
        if (reset) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            edge_q     <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ready_q    <= 1'b1;
            overflow_q <= 1'b0;
            state_q    <= IDLE;
            cnt_q      <= '0;
            cmd_q      <= NOP_CMD;
            data_q     <= '0;
            rd_q       <= 1'b0;
            hdo_q      <= '0;
            hrv_q      <= 1'b0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            edge_q     <= edge_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            ready_q    <= ready_d;
            overflow_q <= overflow_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cmd_q      <= cmd_d;
            data_q     <= data_d;
            rd_q       <= rd_d;
            hdo_q      <= hdo_d;
            hrv_q      <= hrv_d;
        end
    end

    assign bus.hostReady     = ready_q;
    assign bus.hostOverflow  = overflow_q;
    assign bus.hostDataOut   = hdo_q;
    assign bus.hostReadValid = hrv_q;
    assign bus.command       = cmd_q;
    assign bus.data          = data_q;
endmodule
